// File: rtl/async2_rd_packer_pe_pkg.sv
// Shared types and constants for the async2 read-side word packer.
// State encoding, beat word-count width and the legal PACK range live here.
package async2_rd_packer_pe_pkg;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    localparam int MCNT_W   = 4;
    localparam int PACK_MIN = 2;
    localparam int PACK_MAX = 8;

    function automatic bit pack_legal(input int p);
        return (p >= PACK_MIN) && (p <= PACK_MAX);
    endfunction

endpackage

// File: rtl/async2_rd_packer_pe_acc.sv
// Word accumulator: PACK slots plus fill count; beat output is combinational and zero-padded.
// No backpressure of its own; the parent decides when to push and when to drain.
module async2_pack_acc_pe
    import async2_rd_packer_pe_pkg::*;
#(
    parameter int DATASIZE = 8,
    parameter int PACK     = 4
) (
    input  logic                     rclk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATASIZE-1:0]      word,
    input  logic                     clear_to_slot0,
    input  logic                     clear,
    output logic [MCNT_W-1:0]        cnt,
    output logic [DATASIZE*PACK-1:0] beat
);

    logic [DATASIZE-1:0] slot [PACK];

    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            for (int i = 0; i < PACK; i++) slot[i] <= '0;
        end else if (clear_to_slot0) begin
            slot[0] <= word;
            cnt     <= MCNT_W'(1);
        end else if (clear) begin
            cnt <= '0;
        end else if (push) begin
            for (int i = 0; i < PACK; i++)
                if (cnt == MCNT_W'(i)) slot[i] <= word;
            cnt <= cnt + MCNT_W'(1);
        end
    end

    // Stale slots beyond the fill count are masked rather than cleared.
    always_comb begin
        beat = '0;
        for (int i = 0; i < PACK; i++)
            if (MCNT_W'(i) < cnt) beat[i*DATASIZE +: DATASIZE] = slot[i];
    end

endmodule

// File: rtl/async2_rd_packer_pe.sv
// Pops FIFO words and packs PACK of them per valid/ready beat; beat valid one edge after the last pop.
// m_data/m_count hold while m_valid & ~m_ready; popping stops once the accumulator is full and blocked.
module async2_rd_packer_pe
    import async2_rd_packer_pe_pkg::*;
#(
    parameter int DATASIZE = 8,
    parameter int PACK     = 4,
    parameter int CNTW     = 16
) (
    input  logic                     rclk,
    input  logic                     rst,
    input  logic [DATASIZE-1:0]      fifo_rdata,
    input  logic                     fifo_rempty_n,
    output logic                     fifo_rinc,
    input  logic                     flush,
    output logic [DATASIZE*PACK-1:0] m_data,
    output logic [MCNT_W-1:0]        m_count,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [CNTW-1:0]          word_cnt,
    output logic                     busy
);

    generate
        if (!pack_legal(PACK)) begin : g_pack_chk
            $error("async2_rd_packer_pe: PACK must be within 2..8");
        end
    endgenerate

    localparam logic [MCNT_W-1:0] PACK_C = MCNT_W'(PACK);

    state_t                   state, state_nxt;
    logic [MCNT_W-1:0]        acc_cnt;
    logic [DATASIZE*PACK-1:0] acc_beat;
    logic                     out_free, transfer, pop;
    logic                     load_slot0, drain_only;

    always_comb begin
        out_free  = ~m_valid | m_ready;
        transfer  = out_free & ((acc_cnt == PACK_C) | ((state == ST_FLUSH) & (acc_cnt != '0)));
        pop       = ~rst & fifo_rempty_n & (state == ST_ACCUM) & ((acc_cnt < PACK_C) | transfer);
        state_nxt = state;
        case (state)
            // A flush with nothing held and nothing arriving is dropped.
            ST_ACCUM: if (flush && ((acc_cnt != '0) || pop)) state_nxt = ST_FLUSH;
            ST_FLUSH: if (transfer || (acc_cnt == '0)) state_nxt = ST_ACCUM;
            default:  state_nxt = ST_ACCUM;
        endcase
    end

    assign fifo_rinc  = pop;
    assign load_slot0 = transfer & pop;
    assign drain_only = transfer & ~pop;
    assign busy       = (acc_cnt != '0) | m_valid;

    async2_pack_acc_pe #(
        .DATASIZE (DATASIZE),
        .PACK     (PACK)
    ) u_acc (
        .rclk           (rclk),
        .rst            (rst),
        .push           (pop),
        .word           (fifo_rdata),
        .clear_to_slot0 (load_slot0),
        .clear          (drain_only),
        .cnt            (acc_cnt),
        .beat           (acc_beat)
    );

    always_ff @(posedge rclk or posedge rst) begin
        if (rst) state <= ST_ACCUM;
        else     state <= state_nxt;
    end

    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_count <= '0;
        end else if (transfer) begin
            m_valid <= 1'b1;
            m_data  <= acc_beat;
            m_count <= acc_cnt;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

    always_ff @(posedge rclk or posedge rst) begin
        if (rst)      word_cnt <= '0;
        else if (pop) word_cnt <= word_cnt + CNTW'(1);
    end

endmodule

// File: tb/tb_async2_rd_packer_pe.sv
// Directed bench for async2_rd_packer_pe: queue-based FIFO, word-list reference model, per-cycle compare.
module tb_async2_rd_packer_pe;

    localparam int DW = 8;
    localparam int PK = 4;
    localparam int CW = 16;

    logic            rclk = 1'b0;
    logic            rst = 1'b0;
    logic [DW-1:0]   fifo_rdata = 8'hEE;
    logic            fifo_rempty_n = 1'b0;
    logic            fifo_rinc;
    logic            flush = 1'b0;
    logic [DW*PK-1:0] m_data;
    logic [3:0]      m_count;
    logic            m_valid;
    logic            m_ready = 1'b0;
    logic [CW-1:0]   word_cnt;
    logic            busy;

    async2_rd_packer_pe #(.DATASIZE(DW), .PACK(PK), .CNTW(CW)) dut (
        .rclk          (rclk),
        .rst           (rst),
        .fifo_rdata    (fifo_rdata),
        .fifo_rempty_n (fifo_rempty_n),
        .fifo_rinc     (fifo_rinc),
        .flush         (flush),
        .m_data        (m_data),
        .m_count       (m_count),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .word_cnt      (word_cnt),
        .busy          (busy)
    );

    always #5 rclk = ~rclk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // FIFO stand-in: pop seen at the edge, flags/data refreshed just after it.
    logic [DW-1:0] q[$];
    always @(posedge rclk) begin : fifo_p
        logic p;
        p = fifo_rinc;
        #1;
        if (p && q.size() > 0) void'(q.pop_front());
        fifo_rempty_n = (q.size() != 0);
        fifo_rdata    = (q.size() != 0) ? q[0] : 8'hEE;
    end

    // Reference model: list of held words, flushing flag, output beat, pop count.
    logic [DW-1:0]    macc[$];
    logic             mflush = 1'b0;
    logic             mv = 1'b0;
    logic [DW*PK-1:0] mdata = '0;
    logic [3:0]       mcount = '0;
    logic [CW-1:0]    mwc = '0;

    function automatic logic model_xfer();
        int n;
        n = macc.size();
        return (!mv || m_ready) && (n == PK || (mflush && n > 0));
    endfunction

    function automatic logic model_rinc();
        if (rst) return 1'b0;
        return fifo_rempty_n && !mflush && (macc.size() < PK || model_xfer());
    endfunction

    always @(posedge rclk or posedge rst) begin : model_p
        logic xf, pp;
        int n;
        if (rst) begin
            macc.delete();
            mflush = 1'b0; mv = 1'b0; mdata = '0; mcount = '0; mwc = '0;
        end else begin
            n  = macc.size();
            xf = model_xfer();
            pp = model_rinc();
            if (!mflush) begin
                if (flush && (n > 0 || pp)) mflush = 1'b1;
            end else if (xf || n == 0) begin
                mflush = 1'b0;
            end
            if (xf) begin
                mdata = '0;
                for (int i = 0; i < n; i++) mdata[i*DW +: DW] = macc[i];
                mcount = 4'(n);
                mv = 1'b1;
                macc.delete();
            end else if (m_ready) begin
                mv = 1'b0;
            end
            if (pp) begin
                macc.push_back(fifo_rdata);
                mwc = mwc + 1'b1;
            end
        end
    end

    // Accepted-beat log and per-phase statistics.
    logic [DW*PK-1:0] bq_d[$];
    int               bq_c[$];
    int               bq_t[$];
    int rinc_hi = 0, rinc_run = 0, rinc_maxrun = 0, mv_hi = 0, stall_viol = 0;

    always @(posedge rclk) begin
        if (!rst && m_valid && m_ready) begin
            bq_d.push_back(m_data);
            bq_c.push_back(int'(m_count));
            bq_t.push_back(cyc);
        end
    end

    always @(negedge rclk) begin
        cyc++;
        check("m_valid",   m_valid,   mv);
        check("m_data",    m_data,    mdata);
        check("m_count",   m_count,   mcount);
        check("word_cnt",  word_cnt,  mwc);
        check("busy",      busy,      (macc.size() != 0) || mv);
        check("fifo_rinc", fifo_rinc, model_rinc());
        if (fifo_rinc) begin
            rinc_hi++;
            rinc_run++;
            if (rinc_run > rinc_maxrun) rinc_maxrun = rinc_run;
        end else begin
            rinc_run = 0;
        end
        if (m_valid) mv_hi++;
        if (!rst && fifo_rempty_n && !fifo_rinc) stall_viol++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge rclk);
            #2;
        end
    endtask

    task automatic clear_logs();
        bq_d.delete(); bq_c.delete(); bq_t.delete();
        rinc_hi = 0; rinc_run = 0; rinc_maxrun = 0; mv_hi = 0; stall_viol = 0;
    endtask

    task automatic do_reset();
        tick(1);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic wait_beats(input int n, input int budget, input string nm);
        int k;
        k = 0;
        while (bq_d.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        check({nm, "_beats_arrived"}, bq_d.size() >= n, 1'b1);
    endtask

    initial begin
        #1 rst = 1'b1;
        tick(3);
        check("reset_m_valid", m_valid, 1'b0);
        check("reset_word_cnt", word_cnt, '0);
        check("reset_busy", busy, 1'b0);
        rst = 1'b0;

        // Single full beat.
        do_reset();
        m_ready = 1'b1;
        q.push_back(8'h11); q.push_back(8'h22); q.push_back(8'h33); q.push_back(8'h44);
        wait_beats(1, 20, "t1");
        tick(4);
        if (bq_d.size() >= 1) begin
            check("t1_data",  bq_d[0], 32'h44332211);
            check("t1_count", bq_c[0], 4);
        end
        check("t1_word_cnt", word_cnt, 16'd4);
        check("t1_rinc_cycles", rinc_hi, 4);
        check("t1_rinc_run", rinc_maxrun, 4);
        check("t1_valid_cycles", mv_hi, 1);

        // Streaming twelve words.
        clear_logs();
        for (int i = 1; i <= 12; i++) q.push_back(8'(i));
        wait_beats(3, 40, "t2");
        tick(3);
        if (bq_d.size() >= 3) begin
            check("t2_beat0", bq_d[0], 32'h04030201);
            check("t2_beat1", bq_d[1], 32'h08070605);
            check("t2_beat2", bq_d[2], 32'h0C0B0A09);
            check("t2_gap01", bq_t[1] - bq_t[0], 4);
            check("t2_gap12", bq_t[2] - bq_t[1], 4);
        end
        check("t2_no_stall", stall_viol, 0);
        check("t2_word_cnt", word_cnt, 16'd16);

        // Backpressure with eight words available.
        clear_logs();
        m_ready = 1'b0;
        for (int i = 1; i <= 8; i++) q.push_back(8'(i));
        tick(10);
        check("t3_hold_valid", m_valid, 1'b1);
        check("t3_hold_data", m_data, 32'h04030201);
        check("t3_full_no_pop", fifo_rinc, 1'b0);
        check("t3_fifo_drained", q.size(), 0);
        m_ready = 1'b1;
        wait_beats(2, 20, "t3");
        tick(2);
        if (bq_d.size() >= 2) begin
            check("t3_beat0", bq_d[0], 32'h04030201);
            check("t3_beat1", bq_d[1], 32'h08070605);
        end
        check("t3_word_cnt", word_cnt, 16'd24);

        // Partial flush, then a flush with nothing held.
        clear_logs();
        q.push_back(8'hA1); q.push_back(8'hA2); q.push_back(8'hA3);
        tick(8);
        check("t4_busy_before", busy, 1'b1);
        check("t4_no_beat_yet", m_valid, 1'b0);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        wait_beats(1, 10, "t4");
        if (bq_d.size() >= 1) begin
            check("t4_data",  bq_d[0], 32'h00A3A2A1);
            check("t4_count", bq_c[0], 3);
        end
        tick(3);
        clear_logs();
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        tick(8);
        check("t4_empty_flush_beats", bq_d.size(), 0);
        check("t4_idle", busy, 1'b0);

        // Asynchronous reset with a held beat and two words in the accumulator.
        clear_logs();
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) q.push_back(8'(8'h61 + i));
        tick(12);
        check("t5_pre_valid", m_valid, 1'b1);
        check("t5_pre_word_cnt", word_cnt, 16'd33);
        rst = 1'b1;
        #1;
        check("t5_rst_valid", m_valid, 1'b0);
        check("t5_rst_data", m_data, '0);
        check("t5_rst_count", m_count, '0);
        check("t5_rst_word_cnt", word_cnt, '0);
        check("t5_rst_busy", busy, 1'b0);
        check("t5_rst_rinc", fifo_rinc, 1'b0);
        tick(2);
        rst = 1'b0;
        m_ready = 1'b1;
        clear_logs();
        q.push_back(8'h51); q.push_back(8'h52); q.push_back(8'h53); q.push_back(8'h54);
        wait_beats(1, 20, "t5");
        if (bq_d.size() >= 1) begin
            check("t5_clean_data",  bq_d[0], 32'h54535251);
            check("t5_clean_count", bq_c[0], 4);
        end

        // Counter wrap.
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 65538; i++) q.push_back(8'(i));
        begin
            int k;
            k = 0;
            while (q.size() != 0 && k < 70000) begin
                tick(1);
                k++;
            end
        end
        check("t6_fifo_drained", q.size(), 0);
        tick(3);
        check("t6_word_cnt_wrap", word_cnt, 16'd2);
        check("t6_busy_leftover", busy, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/async2_rd_packer_pe.md
Name: async2_rd_packer_PE

Overview:
- Read-side consumer for the async2 FIFO, running in the rclk domain.
- Pops DATASIZE-bit words whenever the FIFO is non-empty (rempty_n), and packs PACK consecutive words into one wide beat.
- Presents each beat on a valid/ready master interface.
- A flush request emits a zero-padded partial beat. A running popped-word counter supports debug and performance monitoring.

Parameters:
- DATASIZE, 8: FIFO word width; must match the FIFO instance.
- PACK, 4: words per output beat; legal range 2..8.
- CNTW, 16: width of the popped-word counter.

Ports:
- rclk  input  1  read-domain clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- fifo_rdata  input  DATASIZE  FIFO read data; valid combinationally while fifo_rempty_n=1.
- fifo_rempty_n  input  1  FIFO non-empty flag, registered in the FIFO.
- fifo_rinc  output  DATASIZE?no: 1  pop strobe; a pop takes effect at the next rclk edge.
- flush  input  1  single-cycle request to emit a partial beat.
- m_data  output  DATASIZE*PACK  packed beat; word 0 (first popped) in bits [DATASIZE-1:0].
- m_count  output  4  number of valid words in m_data (1..PACK).
- m_valid  output  1  beat valid.
- m_ready  input  1  downstream accept.
- word_cnt  output  CNTW  total words popped; wraps.
- busy  output  1  high when any word is held in the accumulator or output register.

Correction to the fifo_rinc line above: its width is 1.

Behaviour:
- Interface decided: one clock, rclk; reset rst is asynchronous and active-high.
- Reset values: fifo_rinc=0 (combinationally gated by rst), m_valid=0, m_data=0, m_count=0, word_cnt=0, busy=0, acc_cnt=0, state=ACCUM.
- Reset mid-operation discards the accumulator and any pending beat; no pop is issued while rst=1.
- Accumulator: register acc[PACK] plus acc_cnt (0..PACK).
  - A popped word is written into slot acc_cnt (or slot 0 if a transfer occurs in the same cycle).
  - Unfilled slots read as 0.
- Output register: out_data, out_count, m_valid.
  - out_free = ~m_valid | m_ready.
- Transfer (acc to output) fires at the rclk edge when out_free and either:
  - (acc_cnt==PACK), or
  - (state==FLUSH and acc_cnt>0).
  - On transfer: m_data<=acc (zero-padded), m_count<=acc_cnt, m_valid<=1.
  - If no transfer fires and m_ready=1, then m_valid<=0.
- Pop rule: fifo_rinc = ~rst & fifo_rempty_n & (state==ACCUM) & (acc_cnt<PACK | transfer).
  - On a pop with transfer, acc_cnt<=1 with the new word in slot 0.
  - On a pop without transfer, acc_cnt<=acc_cnt+1.
  - On a transfer without a pop, acc_cnt<=0.
- Sustained throughput is one word per cycle: with m_ready held high, one beat is emitted every PACK cycles.
- Latency: the last word of a beat is popped at edge N, and m_valid rises after edge N+1.
- State machine:
  - ACCUM: on flush=1, go to FLUSH if acc_cnt>0 or a pop occurs this cycle; otherwise stay in ACCUM (the flush is dropped).
  - FLUSH: popping is inhibited. Return to ACCUM at the edge where the partial transfer fires. While out_free=0, stay in FLUSH; further flush pulses are ignored.
  - A flush arriving in the same cycle the accumulator reaches PACK produces a full beat, then FLUSH finds acc_cnt=0 and returns to ACCUM without emitting an empty beat.
- FIFO emptiness: fifo_rempty_n is trusted as-is.
  - The FIFO's conservative empty flag may hold rempty_n low for one extra cycle after a write; the block simply waits.
  - fifo_rdata is never sampled while fifo_rempty_n=0.
- Backpressure:
  - m_data and m_count hold stable while m_valid=1 and m_ready=0.
  - m_valid never drops without a handshake.
- word_cnt increments by 1 on every pop and wraps modulo 2^CNTW.
- busy = (acc_cnt!=0) | m_valid.

Decomposition:
- Shared include async2_pe_defs.vh holds:
  - state encodings ST_ACCUM=1'b0, ST_FLUSH=1'b1;
  - PACK range check macro;
  - m_count width constant (4).
- One sub-module, async2_pack_acc_PE: the accumulator slots, acc_cnt, and the zero-padded beat output, with inputs push, word, clear_to_slot0, clear.
- The top level holds the FSM, the output register, the pop logic and word_cnt.

Test Plan (DATASIZE=8, PACK=4):
- FIFO preloaded with 0x11,0x22,0x33,0x44, m_ready=1 → one beat m_data=0x44332211, m_count=4, with m_valid high for exactly 1 cycle; word_cnt=4; fifo_rinc high 4 consecutive cycles.
- 12 words 0x01..0x0C streamed, m_ready=1 → beats 0x04030201, 0x08070605, 0x0C0B0A09 on every 4th cycle; fifo_rinc never deasserts while non-empty.
- 8 words available, m_ready=0 for 10 cycles → first beat holds 0x04030201 stable and the accumulator fills with 0x05..0x08. fifo_rinc is 0 once acc_cnt=4, and no word is lost after m_ready=1.
- 3 words 0xA1,0xA2,0xA3, then flush pulse → m_data=0x00A3A2A1, m_count=3; a flush with an empty accumulator produces no beat.
- rst asserted while acc_cnt=2 and m_valid=1 → all outputs 0 immediately (asynchronously); after release, the next 4 words form a clean beat.
- word_cnt preset by streaming 65536+2 words with CNTW=16 → word_cnt=2.
